// File: rtl/sim_monitor_pkg.sv
// sim_monitor_pkg: shared states, halt-reason encodings and halting instruction encodings
package sim_monitor_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam logic [1:0] REASON_NONE   = 2'b00;
    localparam logic [1:0] REASON_ECALL  = 2'b01;
    localparam logic [1:0] REASON_EBREAK = 2'b10;
    localparam logic [1:0] REASON_STALL  = 2'b11;
    localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;
endpackage

// File: rtl/stall_watchdog.sv
// stall_watchdog: pulses expired on the enabled cycle that would make LIMIT consecutive cycles without a kick
module stall_watchdog #(
    parameter int LIMIT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic kick,
    output logic expired
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] cnt;
    // a kick in the same cycle wins over expiry
    assign expired = enable && !kick && cnt == W'(LIMIT - 1);
    always_ff @(posedge clk) begin
        if (rst || !enable || kick || expired) cnt <= '0;
        else                                   cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/sim_halt_monitor.sv
// sim_halt_monitor: end-of-test monitor on the retire port; detects ecall/ebreak/stall and latches a verdict.
// Define SIM_HALT_FINISH_EN to print the verdict on DONE entry and $finish one edge later.
module sim_halt_monitor
    import sim_monitor_pkg::*;
#(
    parameter int STALL_LIMIT  = 1000,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             retire_valid,
    input  logic [31:0]      retire_pc,
    input  logic [31:0]      retire_insn,
    input  logic [31:0]      exit_code,
    output logic             done,
    output logic             pass,
    output logic [1:0]       reason,
    output logic [31:0]      result_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count
);
    state_t state, state_d;
    logic [31:0] drain_cnt, last_pc;
    logic stall_expired, is_ecall, is_ebreak, halt, active;

    stall_watchdog #(.LIMIT(STALL_LIMIT)) u_watchdog (
        .clk(clk),
        .rst(rst),
        .enable(state == RUN),
        .kick(retire_valid),
        .expired(stall_expired)
    );

    assign is_ecall  = retire_valid && retire_insn == INSN_ECALL;
    assign is_ebreak = retire_valid && retire_insn == INSN_EBREAK;
    assign halt      = state == RUN && (is_ecall || is_ebreak || stall_expired);
    assign active    = state == RUN || state == DRAIN;
    assign done      = state == DONE;

    always_comb begin
        state_d = state == IDLE ? RUN :
                  halt ? (DRAIN_CYCLES == 0 ? DONE : DRAIN) :
                  (state == DRAIN && drain_cnt == 32'd1) ? DONE : state;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pass         <= 1'b0;
            reason       <= REASON_NONE;
            result_code  <= '0;
            cycle_count  <= '0;
            retire_count <= '0;
            drain_cnt    <= '0;
            last_pc      <= '0;
        end else begin
            if (active) begin
                cycle_count  <= cycle_count + {{(CNT_W-1){1'b0}}, ~&cycle_count};
                retire_count <= retire_count + {{(CNT_W-1){1'b0}}, retire_valid & ~&retire_count};
            end
            if (state == RUN && retire_valid) last_pc <= retire_pc;
            if (halt) begin
                reason      <= is_ecall ? REASON_ECALL : is_ebreak ? REASON_EBREAK : REASON_STALL;
                result_code <= is_ecall ? exit_code : is_ebreak ? retire_pc : last_pc;
                pass        <= is_ecall && exit_code == 32'd0;
                drain_cnt   <= 32'(DRAIN_CYCLES);
            end else if (state == DRAIN) begin
                drain_cnt <= drain_cnt - 32'd1;
            end
        end
    end

`ifdef SIM_HALT_FINISH_EN
    logic finish_q;
    // $strobe reports the counter values as they settle on the DONE-entry edge
    always_ff @(posedge clk) begin
        if (rst) begin
            finish_q <= 1'b0;
        end else if (state != DONE && state_d == DONE) begin
            finish_q <= 1'b1;
            $strobe("sim_halt_monitor: %s reason=%0d result_code=%h cycle_count=%0d retire_count=%0d",
                    pass ? "PASS" : "FAIL", reason, result_code, cycle_count, retire_count);
        end else if (finish_q) begin
            $finish;
        end
    end
`else
    // harness polls done/pass; no system tasks in this build
`endif
endmodule

// File: tb/tb_sim_halt_monitor.sv
// tb_sim_halt_monitor: directed checks of reset, ecall/ebreak/stall halts, drain timing, reset mid-run and saturation
module tb_sim_halt_monitor;
    import sim_monitor_pkg::*;
    localparam logic [31:0] ADDI = 32'h0010_0093;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic retire_valid = 1'b0;
    logic [31:0] retire_pc = '0, retire_insn = '0, exit_code = '0;

    logic done, pass, nd_done, nd_pass, sat_done, sat_pass;
    logic [1:0] reason, nd_reason, sat_reason;
    logic [31:0] result_code, nd_result, sat_result;
    logic [31:0] cycle_count, retire_count, nd_cycle, nd_retire;
    logic [3:0] sat_cycle, sat_retire;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sim_halt_monitor #(.STALL_LIMIT(8), .DRAIN_CYCLES(4), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .retire_valid(retire_valid), .retire_pc(retire_pc),
        .retire_insn(retire_insn), .exit_code(exit_code), .done(done), .pass(pass),
        .reason(reason), .result_code(result_code), .cycle_count(cycle_count),
        .retire_count(retire_count)
    );

    sim_halt_monitor #(.STALL_LIMIT(8), .DRAIN_CYCLES(0), .CNT_W(32)) u_nodrain (
        .clk(clk), .rst(rst), .retire_valid(retire_valid), .retire_pc(retire_pc),
        .retire_insn(retire_insn), .exit_code(exit_code), .done(nd_done), .pass(nd_pass),
        .reason(nd_reason), .result_code(nd_result), .cycle_count(nd_cycle),
        .retire_count(nd_retire)
    );

    sim_halt_monitor #(.STALL_LIMIT(8), .DRAIN_CYCLES(4), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .retire_valid(retire_valid), .retire_pc(retire_pc),
        .retire_insn(retire_insn), .exit_code(exit_code), .done(sat_done), .pass(sat_pass),
        .reason(sat_reason), .result_code(sat_result), .cycle_count(sat_cycle),
        .retire_count(sat_retire)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [31:0] pc, input logic [31:0] insn, input logic [31:0] code);
        retire_valid = 1'b1;
        retire_pc    = pc;
        retire_insn  = insn;
        exit_code    = code;
        tick();
        retire_valid = 1'b0;
        retire_insn  = '0;
    endtask

    task automatic reset_run();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    function automatic logic [127:0] main_out();
        return {28'd0, done, pass, reason, result_code, cycle_count, retire_count};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        repeat (5) tick();
        chk("reset_outputs", main_out(), '0);
        chk("reset_sat", {sat_done, sat_pass, sat_reason, sat_result, sat_cycle, sat_retire}, '0);
        rst = 1'b0;
        tick();
        chk("run_entry_cycles", cycle_count, 0);
        for (int i = 0; i < 10; i++) retire(32'h1000 + 32'(4 * i), ADDI, 32'd7);
        retire(32'h1028, INSN_ECALL, 32'd0);
        chk("ecall0_reason", reason, 1);
        chk("ecall0_pass", pass, 1);
        chk("ecall0_result", result_code, 0);
        chk("ecall0_done_early", done, 0);
        chk("ecall0_retires", retire_count, 11);
        chk("ecall0_cycles", cycle_count, 11);
        chk("nodrain_done", {nd_done, nd_pass, nd_reason}, 4'b1101);
        repeat (3) tick();
        chk("drain3_done", done, 0);
        tick();
        chk("drain4_done", done, 1);
        chk("done_counts", {cycle_count, retire_count}, {32'd15, 32'd11});
        tick();
        chk("done_frozen", {done, pass, cycle_count, retire_count}, {2'b11, 32'd15, 32'd11});
        chk("nodrain_frozen", nd_cycle, 11);

        reset_run();
        retire(32'h2000, INSN_ECALL, 32'h2A);
        chk("ecall2a_verdict", {pass, reason, result_code}, {1'b0, 2'b01, 32'h2A});

        reset_run();
        retire(32'h8000003C, ADDI, 32'd0);
        retire(32'h80000040, INSN_EBREAK, 32'd0);
        chk("ebreak_verdict", {pass, reason, result_code}, {1'b0, 2'b10, 32'h80000040});
        repeat (4) tick();
        chk("ebreak_done", {done, cycle_count, retire_count}, {1'b1, 32'd6, 32'd2});

        reset_run();
        retire(32'h100, ADDI, 32'd0);
        repeat (7) tick();
        chk("stall_early", reason, 0);
        tick();
        chk("stall_verdict", {pass, reason, result_code}, {1'b0, 2'b11, 32'h100});

        reset_run();
        retire(32'h100, ADDI, 32'd0);
        repeat (7) tick();
        retire(32'h104, ADDI, 32'd0);
        chk("stall_kick_wins", reason, 0);
        repeat (7) tick();
        chk("stall_rearm_early", reason, 0);
        tick();
        chk("stall_rearm", {reason, result_code}, {2'b11, 32'h104});

        reset_run();
        repeat (7) tick();
        chk("stall_noret_early", reason, 0);
        tick();
        chk("stall_noret", {pass, reason, result_code, cycle_count}, {1'b0, 2'b11, 32'h0, 32'd8});

        reset_run();
        retire(32'h3000, INSN_ECALL, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("rst_in_drain", main_out(), '0);
        tick();
        rst = 1'b0;
        tick();
        retire(32'h3000, INSN_ECALL, 32'd0);
        repeat (4) tick();
        chk("pre_rst_done", done, 1);
        rst = 1'b1;
        tick();
        chk("rst_in_done", main_out(), '0);
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) retire(32'h4000 + 32'(4 * i), ADDI, 32'd0);
        retire(32'h400C, INSN_ECALL, 32'd0);
        chk("fresh_verdict", {pass, reason}, 3'b101);
        repeat (4) tick();
        chk("fresh_counts", {done, cycle_count, retire_count}, {1'b1, 32'd8, 32'd4});

        reset_run();
        for (int i = 0; i < 20; i++) retire(32'h5000 + 32'(4 * i), ADDI, 32'd0);
        retire(32'h5050, INSN_ECALL, 32'd0);
        chk("sat_retire_run", sat_retire, 4'hF);
        chk("wide_retire", retire_count, 21);
        repeat (4) tick();
        chk("sat_done", {sat_done, sat_pass, sat_cycle, sat_retire}, {2'b11, 4'hF, 4'hF});
        chk("wide_cycles", cycle_count, 25);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
